// File: rtl/protocol_sequencer_pkg.sv
// Shared definitions for the protocol sequencer: state encoding, DC code and
// parameter defaults.
package protocol_sequencer_pkg;

  localparam int CNT_W_DEF     = 32;
  localparam int NUM_PROTO_DEF = 5;
  localparam int PROTO_W       = 3;

  localparam logic [PROTO_W-1:0] PROTO_DC = '0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RUN    = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/protocol_sequencer_if.sv
// Control/status bundle between the sequence controller (master) and the
// protocol sequencer (slave).
interface protocol_sequencer_if
  import protocol_sequencer_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEF,
  parameter int NUM_PROTO = NUM_PROTO_DEF
);
  logic                 start_i;
  logic                 stop_i;
  logic                 loop_i;
  logic [NUM_PROTO-1:0] mask_i;
  logic [CNT_W-1:0]     settle_i;
  logic [CNT_W-1:0]     dwell_i;
  logic [PROTO_W-1:0]   protocol_o;
  logic                 trigger_o;
  logic                 busy_o;
  logic                 done_o;

  modport slave (
    input  start_i, stop_i, loop_i, mask_i, settle_i, dwell_i,
    output protocol_o, trigger_o, busy_o, done_o
  );

  modport master (
    output start_i, stop_i, loop_i, mask_i, settle_i, dwell_i,
    input  protocol_o, trigger_o, busy_o, done_o
  );
endinterface

// File: rtl/protocol_sequencer_next_sel.sv
// Priority search: lowest enabled protocol code strictly above cur_code.
// With cur_code = PROTO_DC this yields the first enabled protocol.
module protocol_next_sel
  import protocol_sequencer_pkg::*;
#(
  parameter int NUM_PROTO = NUM_PROTO_DEF
) (
  input  logic [NUM_PROTO-1:0] mask,
  input  logic [PROTO_W-1:0]   cur_code,
  output logic [PROTO_W-1:0]   next_code,
  output logic                 valid
);

  // Scan from the top down so the lowest qualifying index wins.
  always_comb begin
    next_code = PROTO_DC;
    valid     = 1'b0;
    for (int k = NUM_PROTO; k >= 1; k--) begin
      if (mask[k-1] && (PROTO_W'(k) > cur_code)) begin
        next_code = PROTO_W'(k);
        valid     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/protocol_sequencer.sv
// Steps through enabled protocols: DC settle, then dwell on each protocol code,
// optionally looping; all outputs registered.
module protocol_sequencer
  import protocol_sequencer_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEF,
  parameter int NUM_PROTO = NUM_PROTO_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  protocol_sequencer_if.slave  bus
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PROTO_W-1:0] cur_q, cur_d;
  logic [PROTO_W-1:0] first_code, next_code;
  logic               first_vld, next_vld;
  logic [PROTO_W-1:0] protocol_d;
  logic               trigger_d, busy_d, done_d;

  // A phase of N cycles lasts max(N,1); the counter expires at zero.
  function automatic logic [CNT_W-1:0] load_count(input logic [CNT_W-1:0] v);
    return (v == '0) ? '0 : v - CNT_W'(1);
  endfunction

  protocol_next_sel #(.NUM_PROTO(NUM_PROTO)) u_first_sel (
    .mask      (bus.mask_i),
    .cur_code  (PROTO_DC),
    .next_code (first_code),
    .valid     (first_vld)
  );

  protocol_next_sel #(.NUM_PROTO(NUM_PROTO)) u_next_sel (
    .mask      (bus.mask_i),
    .cur_code  (cur_q),
    .next_code (next_code),
    .valid     (next_vld)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cur_d   = cur_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start_i && !bus.stop_i && first_vld) begin
          state_d = ST_SETTLE;
          cur_d   = first_code;
          cnt_d   = load_count(bus.settle_i);
        end
      end
      ST_SETTLE: begin
        if (bus.stop_i) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          cur_d   = PROTO_DC;
        end else if (cnt_q == '0) begin
          state_d = ST_RUN;
          cnt_d   = load_count(bus.dwell_i);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (bus.stop_i) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          cur_d   = PROTO_DC;
        end else if (cnt_q == '0) begin
          // Mask and loop are taken as they stand on the expiry cycle.
          if (next_vld) begin
            state_d = ST_SETTLE;
            cur_d   = next_code;
            cnt_d   = load_count(bus.settle_i);
          end else if (bus.loop_i && first_vld) begin
            state_d = ST_SETTLE;
            cur_d   = first_code;
            cnt_d   = load_count(bus.settle_i);
          end else begin
            state_d = ST_DONE;
            cnt_d   = '0;
            cur_d   = PROTO_DC;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        cur_d   = PROTO_DC;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        cur_d   = PROTO_DC;
      end
    endcase

    protocol_d = (state_d == ST_RUN) ? cur_d : PROTO_DC;
    trigger_d  = (state_d == ST_RUN) && (state_q == ST_SETTLE);
    busy_d     = (state_d == ST_SETTLE) || (state_d == ST_RUN);
    done_d     = (state_d == ST_DONE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      cur_q          <= PROTO_DC;
      bus.protocol_o <= PROTO_DC;
      bus.trigger_o  <= 1'b0;
      bus.busy_o     <= 1'b0;
      bus.done_o     <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      cur_q          <= cur_d;
      bus.protocol_o <= protocol_d;
      bus.trigger_o  <= trigger_d;
      bus.busy_o     <= busy_d;
      bus.done_o     <= done_d;
    end
  end

endmodule

// File: doc/protocol_sequencer.md
PROTOCOL_SEQUENCER -- requirements
Module: protocol_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 32, width of dwell/settle counters.
REQ-002 SHALL have parameter NUM_PROTO, default 5, number of selectable non-DC protocols (codes 1..NUM_PROTO).
REQ-003 SHALL have port clk_i, input, 1, the single clock; all logic is in this domain.
REQ-004 SHALL have port rst_i, input, 1, reset, asynchronous, active-high.
REQ-005 SHALL have port start_i, input, 1, level-sampled request to begin a sequence.
REQ-006 SHALL have port stop_i, input, 1, abort request.
REQ-007 SHALL have port loop_i, input, 1, 1 = repeat the sequence indefinitely.
REQ-008 SHALL have port mask_i, input, NUM_PROTO, bit k-1 enables protocol k.
REQ-009 SHALL have port settle_i, input, CNT_W, DC settling cycles before each protocol.
REQ-010 SHALL have port dwell_i, input, CNT_W, cycles each protocol stays selected.
REQ-011 SHALL have port protocol_o, output, 3, protocol select driving the protocol multiplexer (0 = DC).
REQ-012 SHALL have port trigger_o, output, 1, one-cycle pulse on the first cycle of each protocol dwell.
REQ-013 SHALL have port busy_o, output, 1, high in SETTLE and RUN.
REQ-014 SHALL have port done_o, output, 1, one-cycle pulse at sequence completion.

Function
REQ-015 SHALL implement states IDLE, SETTLE, RUN, DONE; all outputs registered.
REQ-016 SHALL, in IDLE with start_i=1, stop_i=0, mask_i!=0 at cycle t, enter SETTLE at t+1 with protocol_o=0, busy_o=1.
REQ-017 SHALL ignore start_i when mask_i=0, or when not in IDLE.
REQ-018 SHALL hold SETTLE for max(settle_i,1) cycles and RUN for max(dwell_i,1) cycles, value sampled on state entry (down-counter loaded with value-1).
REQ-019 SHALL, on SETTLE expiry, enter RUN with protocol_o = selected protocol code and trigger_o=1 for that first RUN cycle only.
REQ-020 SHALL select first protocol = lowest enabled index; next protocol = lowest enabled index above current.
REQ-021 SHALL, on RUN expiry with a higher enabled index, enter SETTLE for it.
REQ-022 SHALL, on RUN expiry with no higher enabled index: loop_i=1 -> SETTLE for lowest enabled index; loop_i=0 -> DONE.
REQ-023 SHALL use mask_i and loop_i as sampled on the RUN-expiry cycle; if mask_i=0 then, go to DONE.
REQ-024 SHALL in DONE drive done_o=1, busy_o=0, protocol_o=0 for exactly one cycle, then IDLE.
REQ-025 SHALL, on stop_i=1 in SETTLE/RUN/DONE, enter IDLE next cycle with protocol_o=0, busy_o=0, no done_o pulse; stop_i beats start_i and expiry.
REQ-026 SHALL keep protocol_o=0 in IDLE, SETTLE, DONE; never output codes above NUM_PROTO.
REQ-027 SHALL count dwell/settle with CNT_W-bit unsigned counters; settle_i/dwell_i of 2^CNT_W-1 SHALL not wrap.

Reset
REQ-028 SHALL, while rst_i=1, immediately force IDLE, protocol_o=0, trigger_o=0, busy_o=0, done_o=0, counters 0.
REQ-029 SHALL, on reset mid-sequence, discard all progress; next start begins from lowest enabled protocol.
REQ-030 SHALL not start on the first edge after rst_i deasserts unless start_i=1 is sampled on that edge.

Structure
REQ-031 SHALL place state encoding, PROTO_DC=0, NUM_PROTO and CNT_W default in a shared package.
REQ-032 SHALL factor the next-enabled-protocol priority search into sub-module protocol_next_sel (inputs: mask, current code; outputs: next code, valid).

Verification
REQ-033 mask=00101, settle=2, dwell=3, loop=0, start at cycle 0 -> protocol_o 0 cycles 1-2, 1 cycles 3-5 (trigger 3), 0 cycles 6-7, 3 cycles 8-10 (trigger 8), done_o=1 cycle 11, IDLE cycle 12.
REQ-034 mask=10000, settle=0, dwell=0, loop=1 -> alternating protocol_o 0,5,0,5... one cycle each, trigger_o on every 5, done_o never.
REQ-035 stop_i=1 during second cycle of RUN (protocol 3) -> next cycle protocol_o=0, busy_o=0, done_o stays 0.
REQ-036 start_i=1 with mask=00000 -> stays IDLE, all outputs 0; start_i=1 while busy -> no effect on timing.
REQ-037 rst_i asserted mid-RUN (protocol 2) -> outputs 0 without clock edge; after release, start runs from lowest enabled.
REQ-038 mask changed 00011->00110 during RUN of protocol 1 -> next protocol 2, then 3, then DONE.
